// File: rtl/uart_rx_if.sv
// Receive-side bus of uart_rx: received byte, its strobe and the error pulses.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic [7:0] uart_data;
  logic       uart_data_stb;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

`ifdef UART_RX_PARITY_EN
  modport master (output uart_data, output uart_data_stb, output frame_err, output parity_err);
  modport slave  (input  uart_data, input  uart_data_stb, input  frame_err, input  parity_err);
`else
  modport master (output uart_data, output uart_data_stb, output frame_err);
  modport slave  (input  uart_data, input  uart_data_stb, input  frame_err);
`endif
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and mid-bit sampling.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a 1->0 edge of rx_s
// S_START  | timing to the middle of the start bit, rejects glitches
// S_DATA   | sampling 8 data bits LSB first
// S_PARITY | sampling the even-parity bit (parity builds only)
// S_STOP   | sampling the stop bit, publishing byte or error
// S_BREAK  | line held low after a framing error, waiting for high
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_TC = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;
  logic [2:0]    state;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          half_tc;
  logic          full_tc;
`ifdef UART_RX_PARITY_EN
  logic          parity_bad;
`endif

  assign half_tc = (bit_timer == HALF_TC);
  assign full_tc = (bit_timer == FULL_TC);

  // Synchronizer resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      bit_timer         <= '0;
      bit_cnt           <= '0;
      shift_reg         <= '0;
      bus.uart_data     <= '0;
      bus.uart_data_stb <= 1'b0;
      bus.frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err    <= 1'b0;
      parity_bad        <= 1'b0;
`endif
    end else begin
      bus.uart_data_stb <= 1'b0;
      bus.frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          bit_timer <= '0;
          bit_cnt   <= '0;
          if (rx_s_d && !rx_s)
            state <= S_START;
        end

        S_START: begin
          if (half_tc) begin
            bit_timer <= '0;
            state     <= rx_s ? S_IDLE : S_DATA;
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end

        S_DATA: begin
          if (full_tc) begin
            bit_timer <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (full_tc) begin
            bit_timer  <= '0;
            parity_bad <= rx_s ^ (^shift_reg);
            state      <= S_STOP;
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end
`endif

        S_STOP: begin
          if (full_tc) begin
            bit_timer <= '0;
            // A low stop bit outranks a parity mismatch.
            if (!rx_s) begin
              bus.frame_err <= 1'b1;
              state         <= S_BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad) begin
              bus.parity_err <= 1'b1;
              state          <= S_IDLE;
`endif
            end else begin
              bus.uart_data     <= shift_reg;
              bus.uart_data_stb <= 1'b1;
              state             <= S_IDLE;
            end
          end else begin
            bit_timer <= bit_timer + TW'(1);
          end
        end

        S_BREAK: begin
          bit_timer <= '0;
          if (rx_s)
            state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int         stb_cnt = 0;
  int         fe_cnt  = 0;
  int         pe_cnt  = 0;
  int         excl_viol = 0;
  int         stb_cyc_q[$];
  logic [7:0] data_q[$];
  int         t_fall = 0;

  always @(negedge clk) begin
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = bus.parity_err;
`else
    pe = 1'b0;
`endif
    if (bus.uart_data_stb) begin
      stb_cnt++;
      stb_cyc_q.push_back(cyc);
      data_q.push_back(bus.uart_data);
    end
    if (bus.frame_err) fe_cnt++;
    if (pe) pe_cnt++;
    if (int'(bus.uart_data_stb) + int'(bus.frame_err) + int'(pe) > 1) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    stb_cnt = 0;
    fe_cnt  = 0;
    pe_cnt  = 0;
    stb_cyc_q.delete();
    data_q.delete();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (N) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par, input logic stop);
    t_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask
`endif

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [7:0] c3;
    int lat;
    c3 = 8'hC3;

    repeat (5) @(negedge clk);
    check("reset_data", {24'h0, bus.uart_data}, 32'h00);
    check("reset_stb", {31'h0, bus.uart_data_stb}, 32'h0);
    check("reset_fe", {31'h0, bus.frame_err}, 32'h0);
    rst = 1'b1;
    idle(2 * N);

    // Single byte with latency window
    clear_mon();
    send_frame(8'h41, 1'b1);
    idle(2 * N);
    check("b41_cnt", stb_cnt, 1);
    check("b41_data", {24'h0, bus.uart_data}, 32'h41);
    lat = (stb_cyc_q.size() > 0) ? stb_cyc_q[0] - t_fall : -1;
    check("b41_latency_ok", {31'h0, (lat >= 154 && lat <= 156)}, 32'h1);
    check("b41_fe", fe_cnt, 0);

    // Back-to-back frames
    clear_mon();
    send_frame(8'h0A, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(2 * N);
    check("b2b_cnt", stb_cnt, 2);
    check("b2b_d0", (data_q.size() > 0) ? {24'h0, data_q[0]} : 32'hDEAD, 32'h0A);
    check("b2b_d1", (data_q.size() > 1) ? {24'h0, data_q[1]} : 32'hDEAD, 32'hFF);
    check("b2b_gap", (stb_cyc_q.size() > 1) ? stb_cyc_q[1] - stb_cyc_q[0] : -1, 160);
    check("b2b_fe", fe_cnt, 0);

    // Glitch rejected, then normal byte
    clear_mon();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * N);
    check("glitch_stb", stb_cnt, 0);
    check("glitch_fe", fe_cnt, 0);
    send_frame(8'h55, 1'b1);
    idle(2 * N);
    check("b55_cnt", stb_cnt, 1);
    check("b55_data", {24'h0, bus.uart_data}, 32'h55);

    // Framing error followed by a long break
    clear_mon();
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (500) @(negedge clk);
    idle(2 * N);
    check("brk_fe", fe_cnt, 1);
    check("brk_stb", stb_cnt, 0);
    check("brk_data_kept", {24'h0, bus.uart_data}, 32'h55);
    send_frame(8'h3C, 1'b1);
    idle(2 * N);
    check("b3c_cnt", stb_cnt, 1);
    check("b3c_data", {24'h0, bus.uart_data}, 32'h3C);

    // Reset in the middle of data bit 4
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    rx = c3[4];
    repeat (N / 2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_data", {24'h0, bus.uart_data}, 32'h00);
    check("mid_rst_stb", {31'h0, bus.uart_data_stb}, 32'h0);
    check("mid_rst_fe", {31'h0, bus.frame_err}, 32'h0);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    clear_mon();
    rst = 1'b1;
    idle(2 * N);
    send_frame(8'h12, 1'b1);
    idle(2 * N);
    check("b12_cnt", stb_cnt, 1);
    check("b12_data", {24'h0, bus.uart_data}, 32'h12);
    check("b12_fe", fe_cnt, 0);

`ifdef UART_RX_PARITY_EN
    clear_mon();
    send_frame_par(8'h07, 1'b0, 1'b1);
    idle(2 * N);
    check("par_bad_pe", pe_cnt, 1);
    check("par_bad_stb", stb_cnt, 0);
    check("par_bad_data_kept", {24'h0, bus.uart_data}, 32'h12);
    clear_mon();
    send_frame_par(8'h07, 1'b1, 1'b1);
    idle(2 * N);
    check("par_ok_stb", stb_cnt, 1);
    check("par_ok_data", {24'h0, bus.uart_data}, 32'h07);
    check("par_ok_pe", pe_cnt, 0);
`endif

    check("pulse_exclusive", excl_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
